// File: rtl/axis_arb_pkg.sv
// ---------------------------------------------------------------------------
// axis_arb_pkg
// Shared types and helpers for the AXI-Stream packet arbiter:
//   - arb_state_t : arbiter state (IDLE / LOCKED)
//   - clog2()     : constant ceiling-log2 used to size port indices
//   - DEF_*       : default bus widths
// ---------------------------------------------------------------------------
package axis_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_PORTS   = 4;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_TUSER_WIDTH = 8;
    localparam int DEF_ID_WIDTH    = 2;

    // Smallest r with 2**r >= n; used as index width (n >= 2 in this design).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_enc.sv
// ---------------------------------------------------------------------------
// rr_priority_enc
// Combinational round-robin priority encoder. Searches the request vector
// starting one position after last_grant and wrapping modulo NUM_PORTS.
// Ports:
//   req        in  NUM_PORTS        request vector, bit i = port i
//   last_grant in  clog2(NUM_PORTS) most recently served port
//   any_req    out 1                at least one request bit is set
//   next_grant out clog2(NUM_PORTS) first requesting port after last_grant
// ---------------------------------------------------------------------------
module rr_priority_enc
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS
) (
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [clog2(NUM_PORTS)-1:0] last_grant,
    output logic                        any_req,
    output logic [clog2(NUM_PORTS)-1:0] next_grant
);

    localparam int IDX_W = clog2(NUM_PORTS);

    logic found;
    int   idx;

    always_comb begin
        any_req    = |req;
        next_grant = '0;
        found      = 1'b0;
        idx        = 0;
        // Offsets 1..NUM_PORTS: last_grant itself is checked last.
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(last_grant) + k) % NUM_PORTS;
            if (!found && req[idx[IDX_W-1:0]]) begin
                next_grant = idx[IDX_W-1:0];
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// axis_pkt_arbiter
// Round-robin arbiter/multiplexer sharing one AXI-Stream output between
// NUM_PORTS upstream streams. Output beat is registered and tagged with the
// source port index on m_axis_tid.
//
// Build option AXIS_ARB_PKT_LOCK_EN:
//   defined   : grant is held from the first accepted beat to the tlast beat.
//   undefined : every accepted beat ends the grant (beat-level round robin);
//               the forwarded m_axis_tlast is still the upstream tlast.
//
// Ports:
//   clk, sync_reset               clock, synchronous active-high reset
//   s_axis_tvalid/tlast/tready    per-port handshake, bit i = port i
//   s_axis_tdata/tuser            flattened, port i at [i*W +: W]
//   m_axis_tvalid/tdata/tuser/tlast/tid   registered output beat
//   m_axis_tready                 downstream ready
//   busy                          high while a grant is held (LOCKED)
// ---------------------------------------------------------------------------
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS   = DEF_NUM_PORTS,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int TUSER_WIDTH = DEF_TUSER_WIDTH,
    parameter int ID_WIDTH    = DEF_ID_WIDTH
) (
    input  logic                             clk,
    input  logic                             sync_reset,
    input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_PORTS*TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [NUM_PORTS-1:0]             s_axis_tlast,
    output logic [NUM_PORTS-1:0]             s_axis_tready,
    output logic                             m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [TUSER_WIDTH-1:0]           m_axis_tuser,
    output logic                             m_axis_tlast,
    output logic [ID_WIDTH-1:0]              m_axis_tid,
    input  logic                             m_axis_tready,
    output logic                             busy
);

    localparam int IDX_W = clog2(NUM_PORTS);

    arb_state_t state, state_n;
    logic [IDX_W-1:0] grant, grant_n;
    logic [IDX_W-1:0] last_grant, last_grant_n;
    logic [IDX_W-1:0] next_grant;
    logic             any_req;
    logic             out_free;
    logic             accept;
    logic             pkt_end;

    logic [DATA_WIDTH-1:0]  in_data [NUM_PORTS];
    logic [TUSER_WIDTH-1:0] in_user [NUM_PORTS];

    logic                   vld_p1;
    logic [DATA_WIDTH-1:0]  tdata_p1;
    logic [TUSER_WIDTH-1:0] tuser_p1;
    logic                   tlast_p1;
    logic [ID_WIDTH-1:0]    tid_p1;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign in_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign in_user[i] = s_axis_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
    end

    rr_priority_enc #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_enc (
        .req        (s_axis_tvalid),
        .last_grant (last_grant),
        .any_req    (any_req),
        .next_grant (next_grant)
    );

    // The output slot can take a new beat when empty or draining this cycle.
    assign out_free = ~vld_p1 | m_axis_tready;
    assign accept   = (state == LOCKED) & s_axis_tvalid[grant] & out_free;

`ifdef AXIS_ARB_PKT_LOCK_EN
    assign pkt_end = s_axis_tlast[grant];
`else
    assign pkt_end = 1'b1;
`endif

    always_comb begin
        s_axis_tready = '0;
        if (state == LOCKED) begin
            s_axis_tready[grant] = out_free;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_n = next_grant;
                    state_n = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && pkt_end) begin
                    last_grant_n = grant;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
        end
    end

    // ---- stage p1: registered output beat ----
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            vld_p1   <= 1'b0;
            tdata_p1 <= '0;
            tuser_p1 <= '0;
            tlast_p1 <= 1'b0;
            tid_p1   <= '0;
        end else if (accept) begin
            vld_p1   <= 1'b1;
            tdata_p1 <= in_data[grant];
            tuser_p1 <= in_user[grant];
            tlast_p1 <= s_axis_tlast[grant];
            tid_p1   <= ID_WIDTH'(grant);
        end else if (m_axis_tready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign m_axis_tvalid = vld_p1;
    assign m_axis_tdata  = tdata_p1;
    assign m_axis_tuser  = tuser_p1;
    assign m_axis_tlast  = tlast_p1;
    assign m_axis_tid    = tid_p1;
    assign busy          = (state == LOCKED);

endmodule

// File: doc/axis_pkt_arbiter.md
Name: axis_pkt_arbiter

Overview:
- Round-robin arbiter/multiplexer that shares one AXI-Stream datapath, typically a downstream FIFO input, between NUM_PORTS upstream streams.
- Each upstream stream is typically the master side of a FIFO with the same tdata/tuser/tlast bus shape.
- The grant is packet-locked: it is held from the first accepted beat until the tlast beat is accepted.
- The output is registered and tagged with the source port index.

Parameters:
- NUM_PORTS, 4, number of requesting input streams (2..16).
- DATA_WIDTH, 32, tdata width per stream.
- TUSER_WIDTH, 8, tuser width per stream.
- ID_WIDTH, 2, width of m_axis_tid; must be at least clog2(NUM_PORTS).

Ports:
- clk  in  1  single clock; every register is clocked on its rising edge.
- sync_reset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  NUM_PORTS  per-port valid; bit i belongs to port i.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  flattened; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tuser  in  NUM_PORTS*TUSER_WIDTH  flattened, same slicing rule.
- s_axis_tlast  in  NUM_PORTS  per-port tlast.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tvalid  out  1  output valid (registered).
- m_axis_tdata  out  DATA_WIDTH  output data (registered).
- m_axis_tuser  out  TUSER_WIDTH  output user (registered).
- m_axis_tlast  out  1  output last (registered).
- m_axis_tid  out  ID_WIDTH  index of the source port of the current output beat.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  high while in LOCKED.

Behaviour:
- Reset: state = IDLE, grant = 0, last_grant = NUM_PORTS-1 (so port 0 wins first).
  - m_axis_tvalid = 0; m_axis_tdata/tuser/tlast/tid = 0; s_axis_tready = 0; busy = 0.
  - Reset asserted mid-packet aborts the packet: the output register is cleared and the remainder of that packet is not forwarded. Recovery is the upstream's responsibility.
- out_free = ~m_axis_tvalid | m_axis_tready (combinational).
- State machine:
  - IDLE: if any s_axis_tvalid bit is set, grant <= first requesting port searching from last_grant+1, wrapping modulo NUM_PORTS; next state LOCKED. Otherwise stay in IDLE. All s_axis_tready bits are 0 in IDLE.
  - LOCKED: s_axis_tready[grant] = out_free; all other ready bits are 0.
    - A beat is accepted when s_axis_tvalid[grant] & s_axis_tready[grant].
    - On an accepted beat, the output register loads that port's data, tuser, tlast and tid = grant, and sets m_axis_tvalid = 1.
    - An accepted beat with tlast = 1 sets last_grant <= grant, state <= IDLE.
- Output register: if no beat is accepted and m_axis_tready = 1, m_axis_tvalid <= 0. If m_axis_tready = 0, the output register holds its contents.
- Latency:
  - Input beat accepted at cycle k appears on m_axis at cycle k+1.
  - Request first seen in IDLE at cycle 0: grant is registered at edge 1, the first beat is accepted in cycle 1 and visible in cycle 2.
  - There is exactly one idle bubble cycle between packets (the IDLE arbitration cycle).
- Boundaries:
  - A granted port dropping tvalid mid-packet keeps the grant; the arbiter waits in LOCKED indefinitely.
  - Requests from other ports during LOCKED are ignored until the next IDLE.
  - A single-beat packet (tlast on the first beat) returns to IDLE after one accepted beat.
  - last_grant wraps from NUM_PORTS-1 to 0.
- Full throughput: with m_axis_tready held high, one beat per cycle within a packet.

Optional Feature:
- Macro: AXIS_ARB_PKT_LOCK_EN.
- Defined: packet-locked arbitration as described above.
- Undefined: beat-level round robin. Every accepted beat is treated as tlast for arbitration purposes, so the state returns to IDLE and last_grant updates after each beat, while the forwarded m_axis_tlast is unchanged. Interleaved ports therefore alternate with one bubble cycle between beats.

Decomposition:
- Package axis_arb_pkg contains:
  - State typedef (IDLE, LOCKED).
  - clog2 constant function.
  - Default-width localparams.
- Sub-module rr_priority_enc: combinational. Inputs are the request vector and last_grant; outputs are any_req and next_grant. Parameterised by NUM_PORTS.

Test Plan:
- Reset then idle: all inputs low for 10 cycles -> m_axis_tvalid = 0 and s_axis_tready = 0 throughout.
- Ports 0 and 2 both offer 3-beat packets (data 0x00..02 and 0x20..22), m_axis_tready = 1 -> output order is 0x00, 0x01, 0x02 (tid 0), one bubble, then 0x20, 0x21, 0x22 (tid 2); tlast set only on 0x02 and 0x22.
- All 4 ports continuously offer 1-beat packets -> tid sequence 0, 1, 2, 3, 0, ..., with one beat every 2 cycles.
- Backpressure: m_axis_tready = 0 for 5 cycles mid-packet on port 1 -> output holds the same beat, s_axis_tready[1] = 0 during the stall, and no beat is lost or duplicated.
- Granted port 3 drops tvalid for 4 cycles mid-packet while port 0 requests -> the grant stays on 3 and port 0 is served only after port 3's tlast.
- sync_reset pulsed during the 2nd beat of a 5-beat packet -> the next cycle shows m_axis_tvalid = 0 and state IDLE, and port 0 wins the next arbitration.
